ft_sync_scheduler: RTL and testbench
====================================

Name: ft_sync_scheduler

Overview:
- Run-control sequencer for the FreezeTime timer block.
- Drives the timer's sim_Start, sim_End and ext_stall inputs.
- Splits a simulation run into fixed simulated-time quanta. At each quantum boundary it freezes the emulated system and performs a request/acknowledge sync with the host.
- Sits between the host control CSRs and the timer instance.

Parameters:
- QW, 32, width of the quantum and epoch counters.
- ACK_TIMEOUT, 1024, cycles allowed in SYNC for sync_ack before abort (must be >= 1).

Ports:
- clock  in  1  fabric clock
- reset  in  1  synchronous, active-high
- cmd_start  in  1  single-cycle pulse; start or restart a run
- cmd_stop  in  1  single-cycle pulse; end the run
- quantum  in  QW  simulated cycles per epoch; sampled on an accepted cmd_start
- sim_time  in  64  simTime from the timer
- sync_ack  in  1  host acknowledge of sync_req
- sim_Start  out  1  to timer
- sim_End  out  1  to timer
- ext_stall  out  1  to timer, and to the core stall OR-tree
- sync_req  out  1  host sync request
- busy  out  1  state is RUN or SYNC
- epoch_count  out  QW  completed syncs since the last accepted start
- timeout_err  out  1  sticky ack-timeout flag
- state  out  3  IDLE=0, RUN=1, SYNC=2, DONE=3

Behaviour:
- Reset:
  - reset is synchronous, active-high; clock is clock.
  - Reset forces state=IDLE and every output to 0. Internal quantum_r, next_sync and wait_cnt are cleared to 0.
- Output derivation:
  - All outputs are registered, decoded from the state register, and change the cycle after the transition.
  - sim_Start=1 in RUN, SYNC and DONE.
  - sim_End=1 in DONE only.
  - ext_stall=1 and sync_req=1 in SYNC only.
  - busy=1 in RUN and SYNC.
- Start acceptance (from IDLE or DONE):
  - Accepted when cmd_start=1, cmd_stop=0 and quantum!=0.
  - On acceptance: quantum_r<=quantum, next_sync<=sim_time+quantum (64-bit, quantum zero-extended), epoch_count<=0, timeout_err<=0, and the block goes to RUN.
  - A start with quantum==0, or with cmd_stop also high, is ignored and the state is held.
- RUN:
  - cmd_stop=1 -> DONE (stop has priority).
  - Else if sim_time >= next_sync (unsigned 64-bit) -> SYNC and wait_cnt<=0.
  - cmd_start in RUN is ignored.
- SYNC:
  - sync_ack=1:
    - epoch_count+1 (wraps modulo 2^QW).
    - next_sync<=next_sync+quantum_r. Catch-up is by quanta only: if sim_time has overshot, the next compare fires again immediately.
    - Go to DONE if stop_pend=1, else to RUN.
  - Else, if wait_cnt==ACK_TIMEOUT-1: timeout_err<=1 and go to DONE.
  - Else wait_cnt+1.
  - cmd_stop in SYNC sets stop_pend. It does not abandon the handshake.
  - stop_pend clears on any exit from SYNC.
  - A sync_ack arriving outside SYNC is ignored.
- DONE: holds until an accepted start. sim_Start=1 with sim_End=1 makes the timer's isSim 0, freezing all timer counters.
- Simultaneous events:
  - Ack and timeout in the same cycle: ack wins.
  - Stop and boundary in the same RUN cycle: stop wins, with no sync and no epoch increment.
- Boundary latency: the boundary is seen on registered sim_time, and ext_stall rises one cycle after the compare. An overshoot of up to 2×(READ_LATENCY+WRITE_LATENCY) simulated cycles is legal.
- Reset mid-SYNC: the block returns to IDLE immediately and sync_req drops the next cycle.

Test Plan:
- Reset then idle: all outputs 0 and state=0 for 10 cycles; a cmd_start with quantum=0 leaves state=0.
- Start with quantum=100 at sim_time=0, sim_time incrementing by 1 per cycle:
  - The compare fires at sim_time=100.
  - sync_req and ext_stall rise the next cycle.
  - Ack after 5 cycles gives epoch_count=1, state returns to RUN, and next sync is at 200.
- Hold sync_ack=0 in SYNC with ACK_TIMEOUT=8: after 8 cycles timeout_err=1, state=DONE, sim_End=1, ext_stall=0. A subsequent accepted start clears timeout_err and epoch_count.
- cmd_stop during SYNC: no exit until ack; on ack epoch_count increments and state goes to DONE, not RUN.
- cmd_stop and boundary in the same cycle: state goes to DONE, sync_req is never asserted, and epoch_count is unchanged.
- Overshoot: sim_time jumps 95→105→130 with quantum=10. Sync at 105 gives next_sync=110 after ack, and RUN re-enters SYNC one cycle later because 130>=110.

Source files
------------

// File: rtl/ft_sync_scheduler.sv
// Run-control sequencer for the FreezeTime timer: slices a run into simulated-time
// quanta and freezes the emulated system for a host req/ack sync at each boundary.
module ft_sync_scheduler #(
  parameter int QW          = 32,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          cmd_start,
  input  logic          cmd_stop,
  input  logic [QW-1:0] quantum,
  input  logic [63:0]   sim_time,
  input  logic          sync_ack,
  output logic          sim_Start,
  output logic          sim_End,
  output logic          ext_stall,
  output logic          sync_req,
  output logic          busy,
  output logic [QW-1:0] epoch_count,
  output logic          timeout_err,
  output logic [2:0]    state
);

  localparam int WW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
  localparam logic [WW-1:0] WAIT_MAX = WW'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE = 3'd0, RUN = 3'd1, SYNC = 3'd2, DONE = 3'd3} st_e;

  typedef struct packed {
    logic       sim_start;
    logic       sim_end;
    logic       ext_stall;
    logic       sync_req;
    logic       busy;
    logic [2:0] state;
  } out_t;

  st_e           state_q, state_d;
  logic [QW-1:0] quantum_q, quantum_d;
  logic [63:0]   next_sync_q, next_sync_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [QW-1:0] epoch_q, epoch_d;
  logic          terr_q, terr_d;
  logic          stop_pend_q, stop_pend_d;
  out_t          out_q, out_d;
  logic          start_ok;

  assign start_ok = cmd_start & ~cmd_stop & (quantum != '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      quantum_q   <= '0;
      next_sync_q <= '0;
      wait_q      <= '0;
      epoch_q     <= '0;
      terr_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      out_q       <= '0;
    end else begin
      state_q     <= state_d;
      quantum_q   <= quantum_d;
      next_sync_q <= next_sync_d;
      wait_q      <= wait_d;
      epoch_q     <= epoch_d;
      terr_q      <= terr_d;
      stop_pend_q <= stop_pend_d;
      out_q       <= out_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    quantum_d   = quantum_q;
    next_sync_d = next_sync_q;
    wait_d      = wait_q;
    epoch_d     = epoch_q;
    terr_d      = terr_q;
    stop_pend_d = stop_pend_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_ok) begin
          state_d     = RUN;
          quantum_d   = quantum;
          next_sync_d = sim_time + 64'(quantum);
          epoch_d     = '0;
          terr_d      = 1'b0;
        end
      end
      RUN: begin
        // stop beats a coincident boundary: no sync, no epoch bump
        if (cmd_stop) state_d = DONE;
        else if (sim_time >= next_sync_q) begin
          state_d = SYNC;
          wait_d  = '0;
        end
      end
      SYNC: begin
        if (cmd_stop) stop_pend_d = 1'b1;
        if (sync_ack) begin
          epoch_d     = epoch_q + 1'b1;
          next_sync_d = next_sync_q + 64'(quantum_q);
          state_d     = (stop_pend_q | cmd_stop) ? DONE : RUN;
          stop_pend_d = 1'b0;
        end else if (wait_q == WAIT_MAX) begin
          terr_d      = 1'b1;
          state_d     = DONE;
          stop_pend_d = 1'b0;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they track state_q.
  always_comb begin
    out_d           = '0;
    out_d.state     = state_d;
    out_d.sim_start = (state_d == RUN) | (state_d == SYNC) | (state_d == DONE);
    out_d.sim_end   = (state_d == DONE);
    out_d.ext_stall = (state_d == SYNC);
    out_d.sync_req  = (state_d == SYNC);
    out_d.busy      = (state_d == RUN) | (state_d == SYNC);
  end

  assign sim_Start   = out_q.sim_start;
  assign sim_End     = out_q.sim_end;
  assign ext_stall   = out_q.ext_stall;
  assign sync_req    = out_q.sync_req;
  assign busy        = out_q.busy;
  assign state       = out_q.state;
  assign epoch_count = epoch_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_ft_sync_scheduler.sv
// Directed bench for ft_sync_scheduler: immediate-assert checks plus an epoch scoreboard.
module tb_ft_sync_scheduler;
  localparam int QW = 32;

  logic          clock = 1'b0;
  logic          reset, cmd_start, cmd_stop, sync_ack;
  logic [QW-1:0] quantum;
  logic [63:0]   sim_time;
  logic          sim_Start, sim_End, ext_stall, sync_req, busy, timeout_err;
  logic [QW-1:0] epoch_count;
  logic [2:0]    state;

  int vectors = 0;
  int miscompares = 0;
  logic [QW-1:0] exp_q[$];

  always #5 clock = ~clock;

  ft_sync_scheduler #(.QW(QW), .ACK_TIMEOUT(8)) dut (
    .clock(clock), .reset(reset), .cmd_start(cmd_start), .cmd_stop(cmd_stop),
    .quantum(quantum), .sim_time(sim_time), .sync_ack(sync_ack),
    .sim_Start(sim_Start), .sim_End(sim_End), .ext_stall(ext_stall),
    .sync_req(sync_req), .busy(busy), .epoch_count(epoch_count),
    .timeout_err(timeout_err), .state(state)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ack cycle: expected epoch goes into the scoreboard, popped once the edge has passed
  task automatic ack_cycle(input logic [QW-1:0] exp_epoch);
    exp_q.push_back(exp_epoch);
    sync_ack = 1'b1;
    tick();
    sync_ack = 1'b0;
    if (exp_q.size() == 0) chk("sb_empty", 1, 0);
    else chk("epoch_sb", 64'(epoch_count), 64'(exp_q.pop_front()));
  endtask

  task automatic start_run(input logic [QW-1:0] q, input logic [63:0] t);
    quantum = q; sim_time = t; cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cmd_start = 1'b0; cmd_stop = 1'b0; sync_ack = 1'b0;
    quantum = '0; sim_time = '0;
    repeat (3) tick();
    reset = 1'b0;

    // reset/idle
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_outs", {sim_Start, sim_End, ext_stall, sync_req, busy, timeout_err, state, epoch_count},
          '0);
    end
    start_run(0, 0);
    chk("q0_ignored", state, 0);
    quantum = 5; cmd_start = 1'b1; cmd_stop = 1'b1;
    tick();
    cmd_start = 1'b0; cmd_stop = 1'b0;
    chk("start_stop_ignored", state, 0);

    // quantum 100 from t=0
    start_run(100, 0);
    chk("run_state", {busy, sim_Start, sim_End, state}, {1'b1, 1'b1, 1'b0, 3'd1});
    sync_ack = 1'b1;  // ack outside SYNC must be ignored
    sim_time = 1;
    tick();
    sync_ack = 1'b0;
    chk("ack_in_run_ignored", epoch_count, 0);
    for (int t = 2; t < 100; t++) begin
      sim_time = 64'(t);
      tick();
    end
    chk("no_sync_99", {sync_req, ext_stall, state}, {1'b0, 1'b0, 3'd1});
    sim_time = 100;
    tick();
    chk("sync_at_100", {sync_req, ext_stall, busy, state}, {1'b1, 1'b1, 1'b1, 3'd2});
    repeat (4) tick();
    chk("sync_hold", state, 2);
    ack_cycle(1);
    chk("back_run", {sync_req, ext_stall, state}, {1'b0, 1'b0, 3'd1});
    sim_time = 199;
    tick();
    chk("no_sync_199", state, 1);
    sim_time = 200;
    tick();
    chk("sync_at_200", state, 2);

    // ack timeout (8 SYNC cycles)
    repeat (7) tick();
    chk("pre_timeout", {state, timeout_err}, {3'd2, 1'b0});
    tick();
    chk("timeout", {state, timeout_err, sim_End, sim_Start, ext_stall, sync_req, busy},
        {3'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    chk("timeout_epoch", epoch_count, 1);
    start_run(10, 1000);
    chk("restart_clears", {state, timeout_err, 32'(epoch_count)}, {3'd1, 1'b0, 32'd0});

    // stop coincident with boundary
    sim_time = 1010; cmd_stop = 1'b1;
    tick();
    cmd_stop = 1'b0;
    chk("stop_wins", {state, sync_req, sim_End}, {3'd3, 1'b0, 1'b1});
    repeat (3) tick();
    chk("stop_wins_hold", {state, sync_req, 32'(epoch_count)}, {3'd3, 1'b0, 32'd0});

    // stop during SYNC waits for ack
    start_run(10, 2000);
    sim_time = 2010;
    tick();
    chk("sync_2010", state, 2);
    cmd_stop = 1'b1;
    tick();
    cmd_stop = 1'b0;
    repeat (2) tick();
    chk("stop_pend_hold", {state, sync_req}, {3'd2, 1'b1});
    ack_cycle(1);
    chk("stop_pend_done", {state, sim_End, sync_req}, {3'd3, 1'b1, 1'b0});

    // overshoot catch-up: next_sync 100 -> 110 -> 120 -> 130 -> 140
    start_run(10, 90);
    sim_time = 95;
    tick();
    chk("no_sync_95", state, 1);
    sim_time = 105;
    tick();
    chk("sync_105", state, 2);
    sim_time = 130;
    ack_cycle(1);
    chk("run_after_105", state, 1);
    tick();
    chk("resync_110", state, 2);
    ack_cycle(2);
    tick();
    chk("resync_120", state, 2);
    ack_cycle(3);
    tick();
    chk("resync_130", state, 2);
    ack_cycle(4);
    tick();
    chk("caught_up", state, 1);

    // reset while in SYNC
    sim_time = 140;
    tick();
    chk("sync_140", sync_req, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("reset_mid_sync", {sync_req, ext_stall, sim_Start, state, 32'(epoch_count)}, '0);
    chk("sb_drained", 64'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
